// File: rtl/error_vec_gen_pkg.sv
// Shared definitions for the error vector generator: parameter-set table,
// memory geometry helpers and the controller state encoding.
`define CLOG2(x) $clog2(x)

package error_vec_gen_pkg;

   // Code length n for each parameter set.
   function automatic int get_n(input int ps);
      case (ps)
         2:       return 4608;
         3:       return 6688;
         4:       return 6960;
         5:       return 8192;
         default: return 3488;
      endcase
   endfunction

   // Field size m (bits per error position) for each parameter set.
   function automatic int get_m(input int ps);
      case (ps)
         2, 3, 4, 5: return 13;
         default:    return 12;
      endcase
   endfunction

   // Error weight t for each parameter set.
   function automatic int get_t(input int ps);
      case (ps)
         2:       return 96;
         3:       return 128;
         4:       return 119;
         5:       return 128;
         default: return 64;
      endcase
   endfunction

   // Number of e_width-bit words needed to hold n bits.
   function automatic int get_e_depth(input int n_bits, input int width);
      return (n_bits + width - 1) / width;
   endfunction

   // Word address width; one spare bit so out-of-range addresses are representable.
   function automatic int get_aw(input int depth);
      return `CLOG2(depth) + 1;
   endfunction

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_ACCEPT = 3'd2,
      S_RD     = 3'd3,
      S_WR     = 3'd4,
      S_DONE   = 3'd5,
      S_READY  = 3'd6
   } state_e;

endpackage

// File: rtl/mem_dual.sv
// Two-port word memory with registered reads. Addresses at or beyond DEPTH
// are ignored on write and read back as zero. Array contents are not reset.
module mem_dual #(
   parameter int WIDTH = 160,
   parameter int DEPTH = 22,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    addr_0,
   input  logic [WIDTH-1:0] data_0,
   input  logic             wren_0,
   input  logic             rden_0,
   output logic [WIDTH-1:0] q_0,
   input  logic [AW-1:0]    addr_1,
   input  logic [WIDTH-1:0] data_1,
   input  logic             wren_1,
   input  logic             rden_1,
   output logic [WIDTH-1:0] q_1
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             in_range_0;
   logic             in_range_1;

   assign in_range_0 = (addr_0 < AW'(DEPTH));
   assign in_range_1 = (addr_1 < AW'(DEPTH));

   // Array writes; port 1 is listed last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (wren_0 && in_range_0) mem_q[addr_0[IW-1:0]] <= data_0;
      if (wren_1 && in_range_1) mem_q[addr_1[IW-1:0]] <= data_1;
   end

   // Registered read data for both ports; holds when the port is not reading.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_0 <= '0;
         q_1 <= '0;
      end else begin
         if (rden_0) q_0 <= in_range_0 ? mem_q[addr_0[IW-1:0]] : '0;
         if (rden_1) q_1 <= in_range_1 ? mem_q[addr_1[IW-1:0]] : '0;
      end
   end

endmodule

// File: rtl/error_vec_gen.sv
// Builds the weight-t error vector: clears the word memory, then sets one
// bit per accepted position with a read-modify-write, and exposes the result
// on a separate always-live read port.
module error_vec_gen
   import error_vec_gen_pkg::*;
#(
   parameter  int parameter_set = 1,
   parameter  int e_width       = 160,
   localparam int n             = get_n(parameter_set),
   localparam int m             = get_m(parameter_set),
   localparam int t             = get_t(parameter_set),
   localparam int E_DEPTH       = get_e_depth(n, e_width),
   localparam int AW            = get_aw(E_DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               pos_valid,
   input  logic [m-1:0]       pos,
   output logic               pos_ready,
   input  logic               rd_e,
   input  logic [AW-1:0]      e_addr,
   output logic [e_width-1:0] error,
   output logic               done,
   output logic               e_valid,
   output logic               range_err,
   output logic               dup_err
);
   localparam int BW = `CLOG2(e_width);
   localparam int CW = `CLOG2(t + 1);

   state_e             state_q;
   logic [AW-1:0]      clr_addr_q;
   logic [AW-1:0]      word_q;
   logic [BW-1:0]      bit_q;
   logic               oor_q;
   logic [CW-1:0]      count_q;
   logic               pos_ready_q;
   logic               done_q;
   logic               e_valid_q;
   logic               range_err_q;
   logic               dup_err_q;

   logic [AW-1:0]      word_d;
   logic [BW-1:0]      bit_d;
   logic               oor_d;

   logic [AW-1:0]      m0_addr;
   logic [e_width-1:0] m0_wdata;
   logic               m0_wren;
   logic               m0_rden;
   logic [e_width-1:0] m0_rdata;
   logic [e_width-1:0] mask;
   logic               hit;

   // Position decode: word index and MSB-first bit index by constant divide/modulo.
   always_comb begin
      word_d = AW'(32'(pos) / 32'(e_width));
      bit_d  = BW'(32'(e_width - 1) - (32'(pos) % 32'(e_width)));
      oor_d  = (32'(pos) >= 32'(n));
   end

   assign mask = {{(e_width-1){1'b0}}, 1'b1} << bit_q;
   assign hit  = |(m0_rdata & mask);

   // Internal port usage: zero-fill in CLEAR, fetch in RD, merge-and-store in WR.
   always_comb begin
      m0_addr  = word_q;
      m0_wdata = '0;
      m0_wren  = 1'b0;
      m0_rden  = 1'b0;
      case (state_q)
         S_CLEAR: begin
            m0_addr = clr_addr_q;
            m0_wren = 1'b1;
         end
         S_RD: m0_rden = 1'b1;
         S_WR: begin
            m0_wren  = !oor_q;
            m0_wdata = m0_rdata | mask;
         end
         default: ;
      endcase
   end

   // Controller with registered handshake, status and flag outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         clr_addr_q  <= '0;
         word_q      <= '0;
         bit_q       <= '0;
         oor_q       <= 1'b0;
         count_q     <= '0;
         pos_ready_q <= 1'b0;
         done_q      <= 1'b0;
         e_valid_q   <= 1'b0;
         range_err_q <= 1'b0;
         dup_err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_READY: begin
               if (start) begin
                  state_q     <= S_CLEAR;
                  clr_addr_q  <= '0;
                  count_q     <= '0;
                  e_valid_q   <= 1'b0;
                  range_err_q <= 1'b0;
                  dup_err_q   <= 1'b0;
               end
            end
            S_CLEAR: begin
               if (clr_addr_q == AW'(E_DEPTH - 1)) begin
                  state_q     <= S_ACCEPT;
                  pos_ready_q <= 1'b1;
               end else begin
                  clr_addr_q <= clr_addr_q + 1'b1;
               end
            end
            S_ACCEPT: begin
               if (pos_valid) begin
                  word_q      <= word_d;
                  bit_q       <= bit_d;
                  oor_q       <= oor_d;
                  pos_ready_q <= 1'b0;
                  state_q     <= S_RD;
               end
            end
            S_RD: state_q <= S_WR;
            S_WR: begin
               count_q <= count_q + 1'b1;
               if (oor_q)    range_err_q <= 1'b1;
               else if (hit) dup_err_q   <= 1'b1;
               if (count_q == CW'(t - 1)) begin
                  state_q   <= S_DONE;
                  done_q    <= 1'b1;
                  e_valid_q <= 1'b1;
               end else begin
                  state_q     <= S_ACCEPT;
                  pos_ready_q <= 1'b1;
               end
            end
            S_DONE:  state_q <= S_READY;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pos_ready = pos_ready_q;
   assign done      = done_q;
   assign e_valid   = e_valid_q;
   assign range_err = range_err_q;
   assign dup_err   = dup_err_q;

   mem_dual #(
      .WIDTH (e_width),
      .DEPTH (E_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk    (clk),
      .rst_n  (rst_n),
      .addr_0 (m0_addr),
      .data_0 (m0_wdata),
      .wren_0 (m0_wren),
      .rden_0 (m0_rden),
      .q_0    (m0_rdata),
      .addr_1 (e_addr),
      .data_1 ('0),
      .wren_1 (1'b0),
      .rden_1 (rd_e),
      .q_1    (error)
   );

endmodule

// File: tb/tb_error_vec_gen.sv
// Randomised bench for error_vec_gen (parameter set 1) with a cycle-level
// reference model built from the position/bit mapping and timing rules.
module tb_error_vec_gen;
   localparam int N  = 3488;
   localparam int M  = 12;
   localparam int T  = 64;
   localparam int EW = 160;
   localparam int ED = 22;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          pos_valid = 1'b0;
   logic [M-1:0]  pos = '0;
   logic          rd_e = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic          pos_ready, done, e_valid, range_err, dup_err;
   logic [EW-1:0] error;

   error_vec_gen #(.parameter_set(1), .e_width(EW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .pos_valid (pos_valid),
      .pos       (pos),
      .pos_ready (pos_ready),
      .rd_e      (rd_e),
      .e_addr    (e_addr),
      .error     (error),
      .done      (done),
      .e_valid   (e_valid),
      .range_err (range_err),
      .dup_err   (dup_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   // ---------------- reference model ----------------
   bit            mbits [N];
   int            mode = 0;          // 0 idle, 1 building, 2 complete
   int            ready_from = 0, pend_at = 0, done_at = -10, count = 0;
   bit            pend = 0, pend_r = 0, pend_d = 0, pend_last = 0;
   bit            exp_ready = 0, exp_done = 0, exp_valid = 0, exp_rerr = 0, exp_derr = 0, exp_rchk = 0;
   logic [EW-1:0] exp_err = '0;

   function automatic logic [EW-1:0] word_of(input int a);
      logic [EW-1:0] w;
      int p;
      w = '0;
      for (int b = 0; b < EW; b++) begin
         p = a * EW + b;
         if (p < N && mbits[p]) w[EW-1-b] = 1'b1;
      end
      return w;
   endfunction

   initial begin
      int c, nc, pi;
      bit r, d;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            mode = 0; pend = 0; done_at = -10;
            exp_ready = 0; exp_done = 0; exp_valid = 0; exp_rerr = 0; exp_derr = 0; exp_rchk = 0;
            cyc = cyc + 1;
            continue;
         end
         c  = cyc;
         nc = c + 1;
         exp_rchk = rd_e && exp_valid;
         if (rd_e) exp_err = word_of(int'(e_addr));
         if (mode == 1 && exp_ready && pos_valid) begin
            pi = int'(pos);
            r  = (pi >= N);
            d  = !r && mbits[pi];
            if (!r) mbits[pi] = 1'b1;
            count++;
            pend = 1; pend_at = c + 3; pend_r = r; pend_d = d; pend_last = (count == T);
            $display("accept pos=%0d cycle=%0d n=%0d", pi, c, count);
         end
         if (start && (mode == 0 || (mode == 2 && c != done_at))) begin
            mode = 1;
            for (int i = 0; i < N; i++) mbits[i] = 1'b0;
            count = 0; ready_from = nc + ED; pend = 0;
            exp_rerr = 0; exp_derr = 0; exp_valid = 0;
         end
         if (pend && nc == pend_at) begin
            pend = 0;
            if (pend_r) exp_rerr = 1;
            if (pend_d) exp_derr = 1;
            if (pend_last) begin
               done_at = nc; mode = 2; exp_valid = 1;
            end else begin
               ready_from = nc;
            end
         end
         exp_done  = (nc == done_at);
         exp_ready = (mode == 1) && !pend && (nc >= ready_from);
         cyc = nc;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_pos_ready", pos_ready, '0);
            chk("rst_done", done, '0);
            chk("rst_e_valid", e_valid, '0);
            chk("rst_range_err", range_err, '0);
            chk("rst_dup_err", dup_err, '0);
            chk("rst_error", error, '0);
         end else begin
            chk("pos_ready", pos_ready, exp_ready);
            chk("done", done, exp_done);
            chk("e_valid", e_valid, exp_valid);
            chk("range_err", range_err, exp_rerr);
            chk("dup_err", dup_err, exp_derr);
            if (exp_rchk) chk("read_data", error, exp_err);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(output int s);
      start = 1'b1;
      s = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input int p, input int gap);
      bit ok;
      ok = 0;
      for (int g = 0; g < gap; g++) begin
         pos = M'($urandom);
         tick();
      end
      pos_valid = 1'b1;
      pos = M'(p);
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (pos_ready) ok = 1;
         tick();
      end
      pos_valid = 1'b0;
      if (!ok) fail_bound("handshake_timeout");
   endtask

   task automatic wait_done(output int d);
      bit ok;
      ok = 0;
      d = -1;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            d = cyc;
         end
         tick();
      end
      if (!ok) fail_bound("done_timeout");
   endtask

   task automatic rd(input int a, output logic [EW-1:0] data);
      rd_e = 1'b1;
      e_addr = AW'(a);
      tick();
      rd_e = 1'b0;
      @(negedge clk);
      data = error;
      $display("read addr=%0d data=%h", a, data);
      @(posedge clk);
      #1;
   endtask

   task automatic run_vector(input int q[$], input int maxgap, output int s, output int d);
      do_start(s);
      foreach (q[i]) send(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      wait_done(d);
   endtask

   task automatic readback_all();
      logic [EW-1:0] w;
      for (int a = 0; a < ED + 3; a++) rd(a, w);
   endtask

   initial begin
      int q[$];
      int s, d;
      logic [EW-1:0] w;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // positions 0..63 in order, pos_valid effectively held high
      q.delete();
      for (int i = 0; i < T; i++) q.push_back(i);
      run_vector(q, 0, s, d);
      chk("done_latency", d - s, 215);
      chk("flags_clean", {range_err, dup_err}, '0);
      rd(0, w);
      chk("word0_ordered", w, {64'hFFFF_FFFF_FFFF_FFFF, 96'h0});
      rd(1, w);
      chk("word1_zero", w, '0);
      rd(30, w);
      chk("oob_addr_zero", w, '0);

      // highest legal position plus low positions
      q.delete();
      q.push_back(N - 1);
      for (int i = 0; i < T - 1; i++) q.push_back(i);
      run_vector(q, 1, s, d);
      rd(ED - 1, w);
      chk("word21_last_pos", w, 160'h1_0000_0000);

      // out-of-range position
      q.delete();
      q.push_back(N);
      for (int i = 0; i < T - 1; i++) q.push_back(i);
      run_vector(q, 0, s, d);
      chk("range_err_set", range_err, 1);
      chk("range_no_dup", dup_err, 0);
      rd(ED - 1, w);
      chk("word21_untouched", w, '0);

      // duplicate position
      q.delete();
      q.push_back(100);
      q.push_back(100);
      for (int i = 0; i < T - 2; i++) q.push_back(i);
      run_vector(q, 2, s, d);
      chk("dup_err_set", dup_err, 1);
      rd(0, w);
      chk("dup_bit59", w[59], 1);
      chk("dup_bit60_clear", w[60], 0);

      // two random vectors with gaps; second must fully replace the first
      for (int v = 0; v < 2; v++) begin
         q.delete();
         for (int i = 0; i < T; i++) q.push_back(int'($urandom_range(0, N - 1)));
         run_vector(q, 3, s, d);
         readback_all();
      end

      // reset in the middle of ACCEPT, then a fresh vector
      begin
         bit ok;
         ok = 0;
         do_start(s);
         for (int i = 0; i < 10; i++) send(int'($urandom_range(0, N - 1)), 1);
         for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (pos_ready) ok = 1;
            else begin
               @(posedge clk);
               #1;
            end
         end
         if (!ok) fail_bound("ready_before_reset");
         @(posedge clk);
         #1;
         rst_n = 1'b0;
         tick();
         tick();
         rst_n = 1'b1;
         tick();
      end
      q.delete();
      for (int i = 0; i < T; i++) q.push_back(int'($urandom_range(0, N - 1)));
      run_vector(q, 2, s, d);
      chk("post_reset_latency_min", (d - s >= 215) ? 1 : 0, 1);
      readback_all();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
